// File: rtl/spi_3wire_pkg.sv
// Shared definitions for the 3-wire SPI master.
//   state_e   : frame sequencer states
//   RW_READ   : value of the rw bit that selects a register read
//   CMD_BITS  : width of the command byte (and of each data byte)
//   build_cmd : packs {rw, addr} into the command byte sent first on the wire
package spi_3wire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam int   CMD_BITS = 8;

  function automatic logic [CMD_BITS-1:0] build_cmd(input logic rw, input logic [6:0] addr);
    return {rw, addr};
  endfunction

endpackage

// File: rtl/spi_3wire_tick_gen.sv
// Prescaler producing the half-period tick for the SPI master.
//   clk, reset : system clock, synchronous active-high reset
//   en         : count while high (the master is busy)
//   clear      : restart the count from zero (command accept)
//   tick       : one-cycle pulse every CLK_DIV enabled clocks
module spi_3wire_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_3wire_master.sv
// Command-driven 3-wire SPI master (register read/write frames).
//   clk, reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; ready only while idle
//   cmd_rw/addr/wdata   : rw=1 read, 7-bit address, write data
//   done                : one-cycle pulse when a frame completes
//   rdata               : last read result, updated with done on reads
//   sclk, ss_n          : SPI clock (idles low) and active-low select
//   sdata_out/oe/in     : shared data line split for the external bidir pad
module spi_3wire_master
  import spi_3wire_pkg::*;
#(
  parameter int CLK_DIV          = 2,
  parameter int READ_DUMMY_BYTES = 1,
  parameter int SETUP_HALFS      = 1,
  parameter int GAP_HALFS        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       ss_n,
  output logic       sdata_out,
  output logic       sdata_oe,
  input  logic       sdata_in
);
  localparam int HALF_MAX = (GAP_HALFS > SETUP_HALFS) ? GAP_HALFS : SETUP_HALFS;
  localparam int HCW      = $clog2(HALF_MAX + 2);
  localparam int BCW      = $clog2(READ_DUMMY_BYTES + 2);
  localparam int TXW      = 2 * CMD_BITS;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [HCW-1:0]   half_cnt_q, half_cnt_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TXW-1:0]   tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             sclk_q, sclk_d;
  logic             ss_n_q, ss_n_d;
  logic             sdo_q, sdo_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             tick, accept;

  assign accept = cmd_valid && ready_q;

  spi_3wire_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_IDLE),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    rw_d       = rw_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    sdo_d      = sdo_q;
    oe_d       = oe_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SETUP;
          tx_d       = {build_cmd(cmd_rw, cmd_addr), cmd_wdata};
          rw_d       = cmd_rw;
          ss_n_d     = 1'b0;
          oe_d       = 1'b1;
          sdo_d      = cmd_rw;
          half_cnt_d = '0;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          if (int'(half_cnt_q) + 1 >= SETUP_HALFS) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd7;
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
      end

      // sclk_q doubles as the slot phase: 0 = low phase, 1 = high phase.
      ST_CMD, ST_WDATA, ST_DUMMY, ST_RDATA: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == ST_RDATA) begin
              rx_d = {rx_q[6:0], sdata_in};
            end
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - 3'd1;  // wraps to 7 at a byte boundary
            // Command and write data form one continuous 16-bit stream.
            if (state_q == ST_CMD || state_q == ST_WDATA) begin
              tx_d  = tx_q << 1;
              sdo_d = tx_q[TXW-2];
            end
            if (bit_cnt_q == 3'd0) begin
              case (state_q)
                ST_CMD: begin
                  if (rw_q == RW_READ) begin
                    oe_d       = 1'b0;
                    sdo_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = (READ_DUMMY_BYTES > 0) ? ST_DUMMY : ST_RDATA;
                  end else begin
                    state_d = ST_WDATA;
                  end
                end
                ST_DUMMY: begin
                  if (int'(byte_cnt_q) + 1 >= READ_DUMMY_BYTES) begin
                    state_d = ST_RDATA;
                  end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                  end
                end
                default: begin
                  state_d    = ST_HOLD;
                  oe_d       = 1'b0;
                  sdo_d      = 1'b0;
                  half_cnt_d = '0;
                end
              endcase
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          if (int'(half_cnt_q) + 1 >= SETUP_HALFS) begin
            state_d    = ST_GAP;
            ss_n_d     = 1'b1;
            oe_d       = 1'b0;
            done_d     = 1'b1;
            half_cnt_d = '0;
            if (rw_q == RW_READ) begin
              rdata_d = rx_q;
            end
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (int'(half_cnt_q) + 1 >= GAP_HALFS) begin
            state_d = ST_IDLE;
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered so that ready is low while reset is held.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      byte_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      rw_q       <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      sdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      rw_q       <= rw_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      sdo_q      <= sdo_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sclk      = sclk_q;
  assign ss_n      = ss_n_q;
  assign sdata_out = sdo_q;
  assign sdata_oe  = oe_q;

endmodule

// File: tb/tb_spi_3wire_master.sv
// Directed bench for spi_3wire_master. Instance 0 uses the default
// parameters, instance 1 uses CLK_DIV=1 and no dummy bytes. Each instance
// has a behavioural register-map slave on a modelled shared data line.
module tb_spi_3wire_master;
  logic clk;
  logic reset;
  logic [1:0] cmd_valid;
  logic [1:0] cmd_rw;
  logic [6:0] cmd_addr [2];
  logic [7:0] cmd_wdata [2];
  wire  [1:0] cmd_ready_w, done_w, sclk_w, ss_n_w, sdo_w, oe_w, sdi_w;
  wire  [7:0] rdata_w [2];

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CD  = (gi == 0) ? 2 : 1;
    localparam int RDB = (gi == 0) ? 1 : 0;

    spi_3wire_master #(.CLK_DIV(CD), .READ_DUMMY_BYTES(RDB)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid[gi]),
      .cmd_ready (cmd_ready_w[gi]),
      .cmd_rw    (cmd_rw[gi]),
      .cmd_addr  (cmd_addr[gi]),
      .cmd_wdata (cmd_wdata[gi]),
      .done      (done_w[gi]),
      .rdata     (rdata_w[gi]),
      .sclk      (sclk_w[gi]),
      .ss_n      (ss_n_w[gi]),
      .sdata_out (sdo_w[gi]),
      .sdata_oe  (oe_w[gi]),
      .sdata_in  (sdi_w[gi])
    );

    // Shared line: master drives when oe is high, otherwise the slave does.
    logic slave_drv;
    assign sdi_w[gi] = oe_w[gi] ? sdo_w[gi] : slave_drv;

    logic       prev_sclk, prev_ss_n;
    logic [7:0] mem [128];
    logic [7:0] cmd_sh, data_sh, last_cmd, last_data;
    int rises, frames, dones, oe_err, stray, ss_low, last_rises, last_ss_low;

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      slave_drv = 1'b0; prev_sclk = 1'b0; prev_ss_n = 1'b1;
      cmd_sh = 8'h00; data_sh = 8'h00; last_cmd = 8'h00; last_data = 8'h00;
      rises = 0; frames = 0; dones = 0; oe_err = 0; stray = 0;
      ss_low = 0; last_rises = 0; last_ss_low = 0;
    end

    always @(negedge clk) begin : mon
      int k;
      if (prev_ss_n && !ss_n_w[gi]) begin
        rises = 0;
        ss_low = 0;
      end
      if (!ss_n_w[gi]) ss_low++;
      if (!prev_sclk && sclk_w[gi]) begin
        if (ss_n_w[gi]) stray++;
        rises++;
        if (rises <= 8) cmd_sh = {cmd_sh[6:0], sdi_w[gi]};
        else data_sh = {data_sh[6:0], sdi_w[gi]};
        if (oe_w[gi] !== ((rises <= 8) || !cmd_sh[7])) oe_err++;
      end
      if (prev_sclk && !sclk_w[gi] && !ss_n_w[gi]) begin
        if (cmd_sh[7] && rises >= 8 * (1 + RDB) && rises < 8 * (2 + RDB)) begin
          k = rises - 8 * (1 + RDB);
          slave_drv = mem[cmd_sh[6:0]][7-k];
        end else begin
          slave_drv = 1'b0;
        end
      end
      if (!prev_ss_n && ss_n_w[gi]) begin
        frames++;
        last_rises = rises;
        last_cmd = cmd_sh;
        last_data = data_sh;
        last_ss_low = ss_low;
        if (!cmd_sh[7] && rises == 16) mem[cmd_sh[6:0]] = data_sh;
        slave_drv = 1'b0;
      end
      if (done_w[gi]) dones++;
      prev_sclk = sclk_w[gi];
      prev_ss_n = ss_n_w[gi];
    end
  end

  // ---------------- stimulus helpers (called after a negedge) ----------------
  task automatic send(input int idx, input logic rw, input logic [6:0] a,
                      input logic [7:0] d, output bit ok);
    int n;
    cmd_rw[idx] = rw; cmd_addr[idx] = a; cmd_wdata[idx] = d; cmd_valid[idx] = 1'b1;
    n = 0;
    while (!cmd_ready_w[idx] && n < 3000) begin @(negedge clk); n++; end
    ok = cmd_ready_w[idx];
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output bit ok);
    int n;
    n = 0;
    while (!done_w[idx] && n < 3000) begin @(negedge clk); n++; end
    ok = done_w[idx];
  endtask

  task automatic wait_idle(input int idx, output bit ok);
    int n;
    n = 0;
    while (!cmd_ready_w[idx] && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    ok = cmd_ready_w[idx];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({cmd_ready_w, done_w, sclk_w, ss_n_w, sdo_w, oe_w} !== 12'b00_00_00_11_00_00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b done=%b sclk=%b ssn=%b sdo=%b oe=%b, want 00 00 00 11 00 00",
               cmd_ready_w, done_w, sclk_w, ss_n_w, sdo_w, oe_w);
    end
    tests_run++;
    if (rdata_w[0] !== 8'h00 || rdata_w[1] !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h/%h want 00/00", rdata_w[0], rdata_w[1]);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready_w !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_ready_after: got %b want 11", cmd_ready_w);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_write();
    bit ok_a, ok_d, ok_i;
    int d0;
    d0 = g_dut[0].dones;
    send(0, 1'b0, 7'h00, 8'hE5, ok_a);
    wait_done(0, ok_d);
    wait_idle(0, ok_i);
    tests_run++;
    if (!(ok_a && ok_d && ok_i)) begin
      tests_failed++;
      $display("FAIL write_handshake: accept=%0d done=%0d idle=%0d want 1 1 1", ok_a, ok_d, ok_i);
    end
    tests_run++;
    if (g_dut[0].last_cmd !== 8'h00 || g_dut[0].last_data !== 8'hE5) begin
      tests_failed++;
      $display("FAIL write_bits: got cmd=%h data=%h want 00 E5", g_dut[0].last_cmd, g_dut[0].last_data);
    end
    tests_run++;
    if (g_dut[0].last_rises != 16 || g_dut[0].last_ss_low != 68) begin
      tests_failed++;
      $display("FAIL write_timing: got rises=%0d ss_low=%0d want 16 68", g_dut[0].last_rises, g_dut[0].last_ss_low);
    end
    tests_run++;
    if (g_dut[0].dones - d0 != 1 || g_dut[0].oe_err != 0) begin
      tests_failed++;
      $display("FAIL write_done_oe: got dones=%0d oe_err=%0d want 1 0", g_dut[0].dones - d0, g_dut[0].oe_err);
    end
    $display("[TB] write addr=00 data=E5: cmd=%h data=%h rises=%0d", g_dut[0].last_cmd, g_dut[0].last_data, g_dut[0].last_rises);
  endtask

  task automatic test_read();
    bit ok_a, ok_d, ok_i;
    send(0, 1'b1, 7'h00, 8'h00, ok_a);
    wait_done(0, ok_d);
    tests_run++;
    if (!(ok_a && ok_d) || rdata_w[0] !== 8'hE5) begin
      tests_failed++;
      $display("FAIL read_rdata: accept=%0d done=%0d rdata=%h want 1 1 E5", ok_a, ok_d, rdata_w[0]);
    end
    wait_idle(0, ok_i);
    tests_run++;
    if (g_dut[0].last_cmd !== 8'h80 || g_dut[0].last_rises != 24 || g_dut[0].oe_err != 0) begin
      tests_failed++;
      $display("FAIL read_frame: got cmd=%h rises=%0d oe_err=%0d want 80 24 0",
               g_dut[0].last_cmd, g_dut[0].last_rises, g_dut[0].oe_err);
    end
    $display("[TB] read addr=00: cmd=%h rdata=%h rises=%0d", g_dut[0].last_cmd, rdata_w[0], g_dut[0].last_rises);
  endtask

  task automatic test_back_to_back();
    bit ok_d, ok_i;
    int n;
    cmd_rw[0] = 1'b0; cmd_addr[0] = 7'h01; cmd_wdata[0] = 8'h91; cmd_valid[0] = 1'b1;
    @(negedge clk);  // accepted on the preceding edge (block was idle)
    cmd_rw[0] = 1'b1;
    wait_done(0, ok_d);
    n = 0;
    while (!cmd_ready_w[0] && n < 3000) begin @(negedge clk); n++; end
    tests_run++;
    if (!ok_d || n != 32) begin
      tests_failed++;
      $display("FAIL b2b_gap: done=%0d clks ss_n-rise to accept=%0d want 1 32", ok_d, n);
    end
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    tests_run++;
    if (ss_n_w[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start: ss_n=%b one clk after accept want 0", ss_n_w[0]);
    end
    wait_done(0, ok_d);
    tests_run++;
    if (!ok_d || rdata_w[0] !== 8'h91) begin
      tests_failed++;
      $display("FAIL b2b_rdata: done=%0d rdata=%h want 1 91", ok_d, rdata_w[0]);
    end
    wait_idle(0, ok_i);
    $display("[TB] back-to-back write 01<=91 / read 01: gap=%0d rdata=%h", n, rdata_w[0]);
  endtask

  task automatic test_div1_nodummy();
    bit ok_a, ok_d, ok_i;
    send(1, 1'b0, 7'h7F, 8'h5A, ok_a);
    wait_done(1, ok_d);
    wait_idle(1, ok_i);
    tests_run++;
    if (!(ok_a && ok_d && ok_i) || g_dut[1].last_cmd !== 8'h7F || g_dut[1].last_data !== 8'h5A
        || g_dut[1].last_rises != 16 || g_dut[1].last_ss_low != 34) begin
      tests_failed++;
      $display("FAIL div1_write: ok=%0d%0d%0d cmd=%h data=%h rises=%0d ss_low=%0d want 111 7F 5A 16 34",
               ok_a, ok_d, ok_i, g_dut[1].last_cmd, g_dut[1].last_data, g_dut[1].last_rises, g_dut[1].last_ss_low);
    end
    send(1, 1'b1, 7'h7F, 8'h00, ok_a);
    wait_done(1, ok_d);
    tests_run++;
    if (!(ok_a && ok_d) || rdata_w[1] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL div1_rdata: ok=%0d%0d rdata=%h want 11 5A", ok_a, ok_d, rdata_w[1]);
    end
    wait_idle(1, ok_i);
    tests_run++;
    if (g_dut[1].last_cmd !== 8'hFF || g_dut[1].last_rises != 16 || g_dut[1].oe_err != 0) begin
      tests_failed++;
      $display("FAIL div1_read_frame: cmd=%h rises=%0d oe_err=%0d want FF 16 0",
               g_dut[1].last_cmd, g_dut[1].last_rises, g_dut[1].oe_err);
    end
    $display("[TB] div1 write/read 7F: rdata=%h rises=%0d", rdata_w[1], g_dut[1].last_rises);
  endtask

  task automatic test_reset_mid_frame();
    bit ok_a, ok_d, ok_i;
    int n, d0;
    d0 = g_dut[0].dones;
    send(0, 1'b0, 7'h02, 8'h3C, ok_a);
    n = 0;
    while (g_dut[0].rises != 13 && n < 3000) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (!ok_a || g_dut[0].rises != 13) begin
      tests_failed++;
      $display("FAIL midrst_reach: accept=%0d rises=%0d want 1 13", ok_a, g_dut[0].rises);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ss_n_w[0] !== 1'b1 || sclk_w[0] !== 1'b0 || oe_w[0] !== 1'b0 || done_w[0] !== 1'b0
        || cmd_ready_w[0] !== 1'b0 || rdata_w[0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_outputs: ssn=%b sclk=%b oe=%b done=%b rdy=%b rdata=%h want 1 0 0 0 0 00",
               ss_n_w[0], sclk_w[0], oe_w[0], done_w[0], cmd_ready_w[0], rdata_w[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready_w[0] !== 1'b1 || g_dut[0].dones != d0) begin
      tests_failed++;
      $display("FAIL midrst_release: rdy=%b dones=%0d want 1 0", cmd_ready_w[0], g_dut[0].dones - d0);
    end
    send(0, 1'b0, 7'h02, 8'h3C, ok_a);
    wait_done(0, ok_d);
    wait_idle(0, ok_i);
    tests_run++;
    if (!(ok_a && ok_d && ok_i) || g_dut[0].last_data !== 8'h3C || g_dut[0].last_rises != 16) begin
      tests_failed++;
      $display("FAIL midrst_recover: ok=%0d%0d%0d data=%h rises=%0d want 111 3C 16",
               ok_a, ok_d, ok_i, g_dut[0].last_data, g_dut[0].last_rises);
    end
    $display("[TB] reset mid-frame then write 02<=3C: data=%h", g_dut[0].last_data);
  endtask

  task automatic test_busy_ignore();
    bit ok_a, ok_d, ok_i;
    int f0, d0;
    f0 = g_dut[0].frames;
    d0 = g_dut[0].dones;
    send(0, 1'b0, 7'h03, 8'hAA, ok_a);
    repeat (10) @(negedge clk);
    cmd_rw[0] = 1'b0; cmd_addr[0] = 7'h04; cmd_wdata[0] = 8'h55; cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    wait_done(0, ok_d);
    repeat (5) @(negedge clk);
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    wait_idle(0, ok_i);
    repeat (200) @(negedge clk);
    tests_run++;
    if (!(ok_a && ok_d && ok_i) || g_dut[0].frames - f0 != 1 || g_dut[0].dones - d0 != 1) begin
      tests_failed++;
      $display("FAIL busy_ignore: ok=%0d%0d%0d frames=%0d dones=%0d want 111 1 1",
               ok_a, ok_d, ok_i, g_dut[0].frames - f0, g_dut[0].dones - d0);
    end
    tests_run++;
    if (g_dut[0].last_cmd !== 8'h03 || g_dut[0].last_data !== 8'hAA) begin
      tests_failed++;
      $display("FAIL busy_frame: cmd=%h data=%h want 03 AA", g_dut[0].last_cmd, g_dut[0].last_data);
    end
    tests_run++;
    if (g_dut[0].stray != 0 || g_dut[1].stray != 0) begin
      tests_failed++;
      $display("FAIL no_stray_sclk: stray=%0d/%0d want 0/0", g_dut[0].stray, g_dut[1].stray);
    end
    $display("[TB] busy pulses ignored: frames=%0d dones=%0d", g_dut[0].frames - f0, g_dut[0].dones - d0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    cmd_valid = 2'b00;
    cmd_rw = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cmd_addr[i] = 7'h00;
      cmd_wdata[i] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_div1_nodummy();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_3wire_master.md
Name: spi_3wire_master

Overview:
- Command-driven master that generates 3-wire SPI frames toward spi_3wire_slave_regmap_top.
- Sits directly upstream of that slave: system logic issues register read/write commands; the block produces sclk, ss_n and the shared sdata line.
- The tri-state pad itself stays in the existing bidir cell, instantiated by the parent.
- Frame format:
  - command byte = {rw, addr[6:0]}, rw=1 read.
  - Sent MSB first; data changes while sclk low; sampled on sclk rise.
  - Write: command byte + data byte.
  - Read: command byte, master releases sdata, READ_DUMMY_BYTES turnaround bytes, then one data byte driven by the slave.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- READ_DUMMY_BYTES, 1, byte slots clocked between read command and read data (>=0).
- SETUP_HALFS, 1, half-periods from ss_n fall to first sclk low phase; also ss_n hold after the last fall.
- GAP_HALFS, 16, minimum ss_n-high half-periods between frames.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_rw  input  1  1=read, 0=write.
- cmd_addr  input  7  register address.
- cmd_wdata  input  8  write data (ignored for reads).
- done  output  1  one-cycle pulse at frame completion.
- rdata  output  8  read data, valid when done pulses for a read; held until the next read completes.
- sclk  output  1  SPI clock, idles low.
- ss_n  output  1  slave select, active-low.
- sdata_out  output  1  to bidir to_pad.
- sdata_oe  output  1  to bidir oe.
- sdata_in  input  1  from bidir pad.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 on the first cycle after; done=0; rdata=8'h00; sclk=0; ss_n=1; sdata_out=0; sdata_oe=0.
- Tick: a prescale counter 0..CLK_DIV-1 produces a one-cycle tick every CLK_DIV clks while not IDLE. All sclk, ss_n and sdata transitions occur on tick cycles only. The counter is cleared on accept.
- Accept: cmd_valid && cmd_ready at an edge captures {rw, addr, wdata}. On that edge: ss_n=0, sdata_oe=1, sdata_out=rw; state -> SETUP. The latency from accept to ss_n low is 1 clk.
- States: IDLE, SETUP, CMD, WDATA, DUMMY, RDATA, HOLD, GAP.
  - SETUP: lasts SETUP_HALFS ticks.
  - Bit slot (CMD/WDATA/DUMMY/RDATA), 2 ticks each:
    - Low phase: sdata_out holds the current bit.
    - Tick: sclk=1. In RDATA this same edge shifts sdata_in into rdata_shift (MSB first).
    - Tick: sclk=0 and advance; the next bit is put on sdata_out on this edge.
  - 3-bit bit counter per byte; DUMMY uses a byte counter over READ_DUMMY_BYTES.
- Transitions:
  - CMD(8 bits) -> WDATA when rw=0.
  - CMD -> DUMMY when rw=1 and READ_DUMMY_BYTES>0, else CMD -> RDATA.
  - WDATA(8) -> HOLD; DUMMY -> RDATA; RDATA(8) -> HOLD.
- sdata_oe for reads: drops to 0 on the falling-edge cycle ending cmd bit 0 and stays 0 through the end of the frame.
- sdata_oe for writes: stays 1 through the falling edge of data bit 0, then drops at entry to HOLD.
- HOLD: SETUP_HALFS ticks with sclk=0. At exit: ss_n=1, sdata_oe=0, done=1 for one clk; rdata <= rdata_shift if read. Then -> GAP.
- GAP: GAP_HALFS ticks with ss_n=1, then -> IDLE (cmd_ready=1).
- A command held valid through GAP is accepted on the first IDLE cycle.
- cmd_valid while not ready is ignored; no queueing.
- Reset mid-frame: the next edge forces the reset values. No done pulse; the frame is abandoned. rdata is cleared.
- sclk edges per frame: write = 16 rising; read = 8*(2+READ_DUMMY_BYTES) rising (24 default).
- No sclk pulses occur while ss_n=1.

Decomposition:
- Package spi_3wire_pkg holds:
  - state enum;
  - constants RW_READ=1'b1 and CMD_BITS=8;
  - function build_cmd(rw, addr) -> 8-bit command byte.
- Optional sub-module spi_3wire_tick_gen (prescaler with clear and tick output); everything else stays in one FSM module.

Test Plan:
- Write addr 0x00 data 0xE5, CLK_DIV=2 -> sdata_out bits sampled on sclk rise = 00 then E5; 16 rising edges; ss_n low for (2*SETUP_HALFS+32)*2 clks; done once; oe never drops mid-frame.
- Read addr 0x00 with the real slave previously written 0xE5 through bidir -> command sampled 0x80; oe=0 after cmd; 24 sclk rises; rdata=0xE5 at done.
- Write 0x01<=0x91, then read 0x01 with cmd_valid held high continuously -> second frame starts exactly GAP_HALFS*CLK_DIV clks after ss_n rises; rdata=0x91.
- Addr 0x7F write 0x5A, CLK_DIV=1, READ_DUMMY_BYTES=0 read-back -> command bytes 0x7F/0xFF; read frame has 16 sclk rises; rdata=0x5A.
- Assert reset during WDATA bit 3 -> next clk: ss_n=1, sclk=0, oe=0, no done, cmd_ready=1 after reset release; a following write completes normally.
- cmd_valid pulsed while busy -> ignored: exactly one frame on the bus, one done.
